is2vid_mode_banks: RTL and testbench
====================================

# is2vid_mode_banks

Mode register bank for the clocked-video output path, sitting directly upstream of the IS2Vid control block. It commits the Avalon writes that the control block forwards via `write_trigger` into per-mode timing banks, and answers each one with `av_write_ack`. It matches the incoming stream format against the valid banks to drive `mode_match`/`mode_change`. At each frame start it hands the matched bank's timing to the output timing generator.

## Interface
Parameters:
- NO_OF_MODES, 2, number of mode banks (1..16)
- BANK_SEL_WIDTH, 4, width of bank select register

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- write_trigger  in  1  forwarded Avalon write (address ≥ 5); held until ack
- av_address  in  8  register address
- av_writedata  in  16  write data
- av_write_ack  out  1  one-cycle write completion
- frame_busy  in  1  timing generator is mid-frame on active bank
- fmt_valid  in  1  one-cycle pulse: new input format measured
- fmt_width  in  16  active samples per line
- fmt_height  in  16  F0 active lines
- fmt_interlaced  in  1  input is interlaced
- mode_match  out  NO_OF_MODES  one-hot matched bank, 0 = none
- mode_change  out  1  one-cycle pulse when mode_match changes
- frame_start  in  1  one-cycle pulse from timing generator
- tg_valid  out  1  tg_params holds a valid mode
- tg_params  out  160  packed mode_params_t of active bank

## Operation
- Register map (addr: field): 5 bank select; 6 ctrl (bit0 interlaced); 7 width; 8 F0 lines; 9 F1 lines; 10 h front porch; 11 h sync; 12 h blank; 13 v front porch; 14 v sync; 15 v blank; 16 valid (bit0).
- Addresses 6–16 write the bank named by bank select. A bank select ≥ NO_OF_MODES, or an address > 16, is acked with no effect.
- Write FSM states:
  - IDLE: on write_trigger, go to STALL if the target bank equals active_bank and tg_valid and frame_busy; otherwise commit the write and go to ACK.
  - STALL: when frame_busy falls, commit the write and go to ACK.
  - ACK: av_write_ack=1; ignore write_trigger (same transaction); go to IDLE.
- Matching on fmt_valid:
  - A bank matches when valid=1, width==fmt_width, F0 lines==fmt_height, and interlaced==fmt_interlaced.
  - When several banks match, the lowest index wins.
  - mode_change fires if the new one-hot value differs from the previous one.
- On frame_start:
  - If mode_match≠0, load the matched bank into tg_params, set active_bank, and set tg_valid=1.
  - Otherwise, tg_valid=0 and tg_params hold their value.
- Widths: all fields are 16-bit unsigned with no arithmetic. Bank select stores the low BANK_SEL_WIDTH bits.

## Timing
- Reset values: av_write_ack=0, mode_match=0, mode_change=0, tg_valid=0, tg_params=0, FSM=IDLE, active_bank=0, all banks 0 (see Configuration).
- Write: trigger seen in cycle T → commit at end of T → ack in T+1 → IDLE in T+2. Throughput is 1 write per 2 cycles.
- Stall: ack comes one cycle after the cycle frame_busy is sampled low.
- Match: fmt_valid in T → mode_match and mode_change in T+1.
- Activation: frame_start in T → tg_params/tg_valid in T+1.
- Simultaneous events:
  - Match or activation in the same cycle as a commit uses pre-write bank contents.
  - fmt_valid together with frame_start: activation uses the old mode_match.
- Reset mid-write: the pending write is dropped and ack is not issued.

## Configuration
- IS2VID_MODE_DEFAULT_BANK0_EN defined: bank 0 resets to 1080p60 and valid=1. Values: width 1920, F0 1080, F1 0, h fp 88, h sync 44, h blank 280, v fp 4, v sync 5, v blank 45, progressive.
- Undefined: all banks reset to zero with valid=0.

## Structure
- Shared package is2vid_pkg:
  - mode_params_t packed struct (ctrl, width, f0_lines, f1_lines, h_fp, h_sync, h_blank, v_fp, v_sync, v_blank; 160 bits);
  - address constants ADDR_BANK_SEL..ADDR_VALID;
  - write FSM state enum.
- One sub-module, is2vid_mode_matcher: combinational compare and priority encode over all banks, registered in the parent.

## Test plan
- Write bank 1 as width 1280, F0 720, progressive, valid=1, then send fmt_valid 1280/720/0 → mode_match=2'b10, mode_change pulse one cycle after fmt_valid.
- Repeat the same fmt_valid → mode_match unchanged, no mode_change.
- Make bank 1 active, raise frame_busy, write addr 7 → no ack until frame_busy falls; ack exactly 1 cycle later.
- Set bank select 5 (NO_OF_MODES=2), write addr 7 → ack in T+1, no bank changes.
- frame_start with mode_match=0 → tg_valid=0 next cycle, tg_params unchanged.
- Assert rst during STALL → ack never issued, outputs at reset values, bank 0 per macro setting.

Source files
------------

// File: rtl/is2vid_pkg.sv
// Shared types for the IS2Vid mode register bank: the per-mode timing
// record, the Avalon register map and the write-FSM state encoding.
package is2vid_pkg;

    // One mode bank's timing record. Field order matches the register
    // map (ctrl at the top), so the packed value is 160 bits.
    typedef struct packed {
        logic [15:0] ctrl;
        logic [15:0] width;
        logic [15:0] f0_lines;
        logic [15:0] f1_lines;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_blank;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_blank;
    } mode_params_t;

    localparam logic [7:0] ADDR_BANK_SEL = 8'd5;
    localparam logic [7:0] ADDR_CTRL     = 8'd6;
    localparam logic [7:0] ADDR_WIDTH    = 8'd7;
    localparam logic [7:0] ADDR_F0_LINES = 8'd8;
    localparam logic [7:0] ADDR_F1_LINES = 8'd9;
    localparam logic [7:0] ADDR_H_FP     = 8'd10;
    localparam logic [7:0] ADDR_H_SYNC   = 8'd11;
    localparam logic [7:0] ADDR_H_BLANK  = 8'd12;
    localparam logic [7:0] ADDR_V_FP     = 8'd13;
    localparam logic [7:0] ADDR_V_SYNC   = 8'd14;
    localparam logic [7:0] ADDR_V_BLANK  = 8'd15;
    localparam logic [7:0] ADDR_VALID    = 8'd16;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_STALL = 2'd1,
        WR_ACK   = 2'd2
    } wr_state_e;

    // 1080p60, progressive.
    localparam mode_params_t MODE_1080P60 = '{
        ctrl:     16'd0,
        width:    16'd1920,
        f0_lines: 16'd1080,
        f1_lines: 16'd0,
        h_fp:     16'd88,
        h_sync:   16'd44,
        h_blank:  16'd280,
        v_fp:     16'd4,
        v_sync:   16'd5,
        v_blank:  16'd45
    };

    // Returns p with the field selected by addr replaced by d.
    // Addresses outside 6..15 leave p untouched.
    function automatic mode_params_t set_field(
        input mode_params_t p,
        input logic [7:0]   addr,
        input logic [15:0]  d
    );
        mode_params_t r;
        r = p;
        case (addr)
            ADDR_CTRL:     r.ctrl     = d;
            ADDR_WIDTH:    r.width    = d;
            ADDR_F0_LINES: r.f0_lines = d;
            ADDR_F1_LINES: r.f1_lines = d;
            ADDR_H_FP:     r.h_fp     = d;
            ADDR_H_SYNC:   r.h_sync   = d;
            ADDR_H_BLANK:  r.h_blank  = d;
            ADDR_V_FP:     r.v_fp     = d;
            ADDR_V_SYNC:   r.v_sync   = d;
            ADDR_V_BLANK:  r.v_blank  = d;
            default:       r          = p;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/is2vid_mode_matcher.sv
// Combinational format matcher: compares the measured input format
// against every valid bank and returns a one-hot of the lowest match.
// Ports: banks_i/valid_i (bank contents), fmt_* (measured format),
//        match_o (one-hot, 0 = no bank matches).
module is2vid_mode_matcher
    import is2vid_pkg::*;
#(
    parameter int NO_OF_MODES = 2
) (
    input  mode_params_t [NO_OF_MODES-1:0] banks_i,
    input  logic [NO_OF_MODES-1:0]         valid_i,
    input  logic [15:0]                    fmt_width_i,
    input  logic [15:0]                    fmt_height_i,
    input  logic                           fmt_interlaced_i,
    output logic [NO_OF_MODES-1:0]         match_o
);

    logic [NO_OF_MODES-1:0] hit;

    always_comb begin
        for (int i = 0; i < NO_OF_MODES; i++) begin
            hit[i] = valid_i[i]
                && (banks_i[i].width == fmt_width_i)
                && (banks_i[i].f0_lines == fmt_height_i)
                && (banks_i[i].ctrl[0] == fmt_interlaced_i);
        end
    end

    // Scan from the top so the lowest matching index wins.
    always_comb begin
        match_o = '0;
        for (int i = NO_OF_MODES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                match_o    = '0;
                match_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/is2vid_mode_banks.sv
// Mode register bank for the clocked-video output path: commits
// forwarded Avalon writes into per-mode timing banks, matches the
// measured input format against valid banks and hands the matched
// bank to the timing generator at frame start.
// Ports: clk/rst (async, active-high); write_trigger, av_address,
//   av_writedata, av_write_ack (register writes); frame_busy;
//   fmt_* (measured format); mode_match, mode_change; frame_start,
//   tg_valid, tg_params (timing generator hand-off).
// Build option: IS2VID_MODE_DEFAULT_BANK0_EN makes bank 0 reset to a
//   valid 1080p60 mode; otherwise every bank resets to zero, invalid.
module is2vid_mode_banks
    import is2vid_pkg::*;
#(
    parameter int NO_OF_MODES    = 2,
    parameter int BANK_SEL_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_trigger,
    input  logic [7:0]             av_address,
    input  logic [15:0]            av_writedata,
    output logic                   av_write_ack,
    input  logic                   frame_busy,
    input  logic                   fmt_valid,
    input  logic [15:0]            fmt_width,
    input  logic [15:0]            fmt_height,
    input  logic                   fmt_interlaced,
    output logic [NO_OF_MODES-1:0] mode_match,
    output logic                   mode_change,
    input  logic                   frame_start,
    output logic                   tg_valid,
    output logic [159:0]           tg_params
);

`ifdef IS2VID_MODE_DEFAULT_BANK0_EN
    localparam mode_params_t BANK0_RST   = MODE_1080P60;
    localparam logic         BANK0_V_RST = 1'b1;
`else
    localparam mode_params_t BANK0_RST   = '0;
    localparam logic         BANK0_V_RST = 1'b0;
`endif

    wr_state_e state_q, state_d;

    mode_params_t [NO_OF_MODES-1:0] banks_q, banks_d;
    logic [NO_OF_MODES-1:0]         valid_q, valid_d;
    logic [BANK_SEL_WIDTH-1:0]      bank_sel_q, bank_sel_d;
    logic [BANK_SEL_WIDTH-1:0]      active_q, active_d;

    logic [7:0]  wr_addr_q;
    logic [15:0] wr_data_q;

    logic [NO_OF_MODES-1:0] match_q, match_d;
    logic                   change_q, change_d;
    logic                   tgv_q, tgv_d;
    mode_params_t           tgp_q, tgp_d;

    logic [NO_OF_MODES-1:0] match_now;

    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        sel_ok;
    logic        bank_wr;
    logic        hits_active;
    logic        commit;

    is2vid_mode_matcher #(
        .NO_OF_MODES (NO_OF_MODES)
    ) u_matcher (
        .banks_i          (banks_q),
        .valid_i          (valid_q),
        .fmt_width_i      (fmt_width),
        .fmt_height_i     (fmt_height),
        .fmt_interlaced_i (fmt_interlaced),
        .match_o          (match_now)
    );

    // In STALL the original request is replayed from the capture
    // registers, so the commit does not depend on the master keeping
    // its address/data stable.
    always_comb begin
        wr_addr = (state_q == WR_IDLE) ? av_address : wr_addr_q;
        wr_data = (state_q == WR_IDLE) ? av_writedata : wr_data_q;
        sel_ok  = int'(bank_sel_q) < NO_OF_MODES;
        bank_wr = sel_ok
            && (wr_addr >= ADDR_CTRL)
            && (wr_addr <= ADDR_VALID);
        // Only a bank write into the bank the generator is currently
        // scanning out must wait for the frame to finish.
        hits_active = bank_wr
            && (bank_sel_q == active_q)
            && tgv_q
            && frame_busy;
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        unique case (state_q)
            WR_IDLE: begin
                if (write_trigger) begin
                    if (hits_active) begin
                        state_d = WR_STALL;
                    end else begin
                        commit  = 1'b1;
                        state_d = WR_ACK;
                    end
                end
            end
            WR_STALL: begin
                if (!frame_busy) begin
                    commit  = 1'b1;
                    state_d = WR_ACK;
                end
            end
            WR_ACK: begin
                state_d = WR_IDLE;
            end
            default: begin
                state_d = WR_IDLE;
            end
        endcase
    end

    always_comb begin
        banks_d    = banks_q;
        valid_d    = valid_q;
        bank_sel_d = bank_sel_q;
        if (commit) begin
            if (wr_addr == ADDR_BANK_SEL) begin
                bank_sel_d = wr_data[BANK_SEL_WIDTH-1:0];
            end else if (bank_wr) begin
                for (int i = 0; i < NO_OF_MODES; i++) begin
                    if (bank_sel_q == BANK_SEL_WIDTH'(i)) begin
                        if (wr_addr == ADDR_VALID) begin
                            valid_d[i] = wr_data[0];
                        end else begin
                            banks_d[i] = set_field(
                                banks_q[i], wr_addr, wr_data);
                        end
                    end
                end
            end
        end
    end

    // Matching and activation read the registered banks, so a commit
    // in the same cycle is seen only from the next cycle on.
    // Activation uses the registered mode_match, i.e. the value from
    // before any fmt_valid arriving in the same cycle.
    always_comb begin
        match_d  = match_q;
        change_d = 1'b0;
        tgv_d    = tgv_q;
        tgp_d    = tgp_q;
        active_d = active_q;
        if (fmt_valid) begin
            match_d  = match_now;
            change_d = (match_now != match_q);
        end
        if (frame_start) begin
            if (|match_q) begin
                tgv_d = 1'b1;
                for (int i = 0; i < NO_OF_MODES; i++) begin
                    if (match_q[i]) begin
                        tgp_d    = banks_q[i];
                        active_d = BANK_SEL_WIDTH'(i);
                    end
                end
            end else begin
                tgv_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WR_IDLE;
            banks_q    <= '0;
            banks_q[0] <= BANK0_RST;
            valid_q    <= '0;
            valid_q[0] <= BANK0_V_RST;
            bank_sel_q <= '0;
            active_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            match_q    <= '0;
            change_q   <= 1'b0;
            tgv_q      <= 1'b0;
            tgp_q      <= '0;
        end else begin
            state_q    <= state_d;
            banks_q    <= banks_d;
            valid_q    <= valid_d;
            bank_sel_q <= bank_sel_d;
            active_q   <= active_d;
            if (state_q == WR_IDLE && write_trigger) begin
                wr_addr_q <= av_address;
                wr_data_q <= av_writedata;
            end
            match_q    <= match_d;
            change_q   <= change_d;
            tgv_q      <= tgv_d;
            tgp_q      <= tgp_d;
        end
    end

    assign av_write_ack = (state_q == WR_ACK);
    assign mode_match   = match_q;
    assign mode_change  = change_q;
    assign tg_valid     = tgv_q;
    assign tg_params    = tgp_q;

endmodule

// File: tb/tb_is2vid_mode_banks.sv
// Self-checking bench for is2vid_mode_banks: directed scenarios plus
// randomized cycles compared against a behavioural model.
module tb_is2vid_mode_banks;

    localparam int NM = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          write_trigger = 1'b0;
    logic [7:0]    av_address = '0;
    logic [15:0]   av_writedata = '0;
    logic          av_write_ack;
    logic          frame_busy = 1'b0;
    logic          fmt_valid = 1'b0;
    logic [15:0]   fmt_width = '0;
    logic [15:0]   fmt_height = '0;
    logic          fmt_interlaced = 1'b0;
    logic [NM-1:0] mode_match;
    logic          mode_change;
    logic          frame_start = 1'b0;
    logic          tg_valid;
    logic [159:0]  tg_params;

    int chk = 0;
    int err = 0;

    is2vid_mode_banks #(
        .NO_OF_MODES    (NM),
        .BANK_SEL_WIDTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .write_trigger  (write_trigger),
        .av_address     (av_address),
        .av_writedata   (av_writedata),
        .av_write_ack   (av_write_ack),
        .frame_busy     (frame_busy),
        .fmt_valid      (fmt_valid),
        .fmt_width      (fmt_width),
        .fmt_height     (fmt_height),
        .fmt_interlaced (fmt_interlaced),
        .mode_match     (mode_match),
        .mode_change    (mode_change),
        .frame_start    (frame_start),
        .tg_valid       (tg_valid),
        .tg_params      (tg_params)
    );

    always #5 clk = ~clk;

    // Behavioural model: field k of a bank is register address 6+k.
    logic [15:0]   m_f [NM][10];
    logic          m_v [NM];
    logic [3:0]    m_sel;
    logic [NM-1:0] m_match;
    logic          m_tgv;
    logic [159:0]  m_tgp;
    int            m_active;

    function automatic void model_reset();
        for (int b = 0; b < NM; b++) begin
            for (int k = 0; k < 10; k++) m_f[b][k] = '0;
            m_v[b] = 1'b0;
        end
`ifdef IS2VID_MODE_DEFAULT_BANK0_EN
        m_f[0][1] = 16'd1920;
        m_f[0][2] = 16'd1080;
        m_f[0][4] = 16'd88;
        m_f[0][5] = 16'd44;
        m_f[0][6] = 16'd280;
        m_f[0][7] = 16'd4;
        m_f[0][8] = 16'd5;
        m_f[0][9] = 16'd45;
        m_v[0] = 1'b1;
`endif
        m_sel = '0;
        m_match = '0;
        m_tgv = 1'b0;
        m_tgp = '0;
        m_active = 0;
    endfunction

    function automatic void model_write(input logic [7:0] a,
                                        input logic [15:0] d);
        int bi;
        int ia;
        bi = int'(m_sel);
        ia = int'(a);
        if (ia == 5) begin
            m_sel = d[3:0];
        end else if (ia >= 6 && ia <= 16 && bi < NM) begin
            if (ia == 16) m_v[bi] = d[0];
            else m_f[bi][ia-6] = d;
        end
    endfunction

    function automatic logic [NM-1:0] model_match(
        input logic [15:0] w, input logic [15:0] h, input logic il);
        logic [NM-1:0] r;
        r = '0;
        for (int b = 0; b < NM; b++) begin
            if (r == '0 && m_v[b] && m_f[b][1] == w
                && m_f[b][2] == h && m_f[b][0][0] == il)
                r[b] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [159:0] model_pack(input int b);
        logic [159:0] p;
        for (int k = 0; k < 10; k++) p[159-16*k -: 16] = m_f[b][k];
        return p;
    endfunction

    // One non-stalling transaction cycle followed by one quiet cycle.
    task automatic cycle_op(input logic wr, input logic [7:0] a,
                            input logic [15:0] d, input logic fv,
                            input logic [15:0] w, input logic [15:0] h,
                            input logic il, input logic fs,
                            input string tag);
        logic [NM-1:0] nm;
        logic exp_chg;
        write_trigger = wr;
        av_address = a;
        av_writedata = d;
        fmt_valid = fv;
        fmt_width = w;
        fmt_height = h;
        fmt_interlaced = il;
        frame_start = fs;
        exp_chg = 1'b0;
        if (fs) begin
            if (m_match != '0) begin
                for (int b = 0; b < NM; b++)
                    if (m_match[b]) begin
                        m_tgp = model_pack(b);
                        m_active = b;
                    end
                m_tgv = 1'b1;
            end else begin
                m_tgv = 1'b0;
            end
        end
        if (fv) begin
            nm = model_match(w, h, il);
            exp_chg = (nm != m_match);
            m_match = nm;
        end
        if (wr) model_write(a, d);
        @(negedge clk);
        write_trigger = 1'b0;
        fmt_valid = 1'b0;
        frame_start = 1'b0;
        chk++;
        if (av_write_ack !== wr) begin
            err++;
            $display("FAIL %s ack got %0b want %0b", tag, av_write_ack, wr);
        end
        chk++;
        if (mode_match !== m_match) begin
            err++;
            $display("FAIL %s mode_match got %b want %b",
                     tag, mode_match, m_match);
        end
        chk++;
        if (mode_change !== exp_chg) begin
            err++;
            $display("FAIL %s mode_change got %0b want %0b",
                     tag, mode_change, exp_chg);
        end
        chk++;
        if (tg_valid !== m_tgv) begin
            err++;
            $display("FAIL %s tg_valid got %0b want %0b",
                     tag, tg_valid, m_tgv);
        end
        chk++;
        if (tg_params !== m_tgp) begin
            err++;
            $display("FAIL %s tg_params got %h want %h",
                     tag, tg_params, m_tgp);
        end
        @(negedge clk);
        chk++;
        if (av_write_ack !== 1'b0 || mode_change !== 1'b0) begin
            err++;
            $display("FAIL %s quiet ack/chg got %0b/%0b want 0/0",
                     tag, av_write_ack, mode_change);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d,
                      input string tag);
        cycle_op(1'b1, a, d, 1'b0, '0, '0, 1'b0, 1'b0, tag);
    endtask

    task automatic fmt(input logic [15:0] w, input logic [15:0] h,
                       input logic il, input string tag);
        cycle_op(1'b0, '0, '0, 1'b1, w, h, il, 1'b0, tag);
    endtask

    task automatic fstart(input string tag);
        cycle_op(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk++;
        if (av_write_ack !== 1'b0 || mode_match !== '0
            || mode_change !== 1'b0 || tg_valid !== 1'b0
            || tg_params !== '0) begin
            err++;
            $display("FAIL %s outputs got ack=%0b mm=%b chg=%0b tgv=%0b tgp=%h want all 0",
                     tag, av_write_ack, mode_match, mode_change,
                     tg_valid, tg_params);
        end
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_release");
        // Bank 0 default is observable through matching + activation.
        fmt(16'd1920, 16'd1080, 1'b0, "reset_bank0_match");
        fstart("reset_bank0_activate");
        fmt(16'd1, 16'd1, 1'b0, "reset_clear_match");
    endtask

    task automatic test_match();
        wr(8'd5, 16'd1, "m_sel1");
        wr(8'd6, 16'd0, "m_ctrl");
        wr(8'd7, 16'd1280, "m_width");
        wr(8'd8, 16'd720, "m_f0");
        wr(8'd16, 16'd1, "m_valid");
        fmt(16'd1280, 16'd720, 1'b0, "m_first");
        chk++;
        if (mode_match !== 2'b10) begin
            err++;
            $display("FAIL m_onehot got %b want 10", mode_match);
        end
        fmt(16'd1280, 16'd720, 1'b0, "m_repeat");
        fmt(16'd1280, 16'd720, 1'b1, "m_interlace_diff");
        fmt(16'd1280, 16'd720, 1'b0, "m_back");
    endtask

    task automatic test_stall();
        fstart("s_activate1");
        frame_busy = 1'b1;
        write_trigger = 1'b1;
        av_address = 8'd7;
        av_writedata = 16'd1281;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk++;
            if (av_write_ack !== 1'b0) begin
                err++;
                $display("FAIL s_hold%0d ack got %0b want 0",
                         i, av_write_ack);
            end
        end
        frame_busy = 1'b0;
        @(negedge clk);
        chk++;
        if (av_write_ack !== 1'b1) begin
            err++;
            $display("FAIL s_release ack got %0b want 1", av_write_ack);
        end
        write_trigger = 1'b0;
        model_write(8'd7, 16'd1281);
        @(negedge clk);
        chk++;
        if (av_write_ack !== 1'b0) begin
            err++;
            $display("FAIL s_after ack got %0b want 0", av_write_ack);
        end
        fstart("s_reload");
        // Writes to a bank other than the active one never stall.
        frame_busy = 1'b1;
        wr(8'd5, 16'd0, "s_sel0_busy");
        wr(8'd10, 16'd77, "s_bank0_busy");
        wr(8'd5, 16'd1, "s_sel1_busy");
        frame_busy = 1'b0;
    endtask

    task automatic test_bad_sel();
        wr(8'd5, 16'd5, "b_sel5");
        wr(8'd7, 16'd999, "b_w7");
        wr(8'd16, 16'd0, "b_valid");
        wr(8'd17, 16'hffff, "b_addr17");
        wr(8'd5, 16'h0011, "b_sel_lowbits");
        wr(8'd200, 16'h1234, "b_addr200");
        fmt(16'd1281, 16'd720, 1'b0, "b_rematch");
        fstart("b_activate");
    endtask

    task automatic test_no_match_frame();
        fmt(16'd111, 16'd222, 1'b0, "n_nomatch");
        fstart("n_fs_invalid");
        fstart("n_fs_again");
    endtask

    task automatic test_simultaneous();
        // Activation sees the old (empty) match, not the new one.
        cycle_op(1'b0, '0, '0, 1'b1, 16'd1281, 16'd720, 1'b0, 1'b1,
                 "x_fmt_fs");
        // Match sees pre-write contents of the bank being written.
        cycle_op(1'b1, 8'd8, 16'd721, 1'b1, 16'd1281, 16'd721, 1'b0,
                 1'b1, "x_wr_fmt_fs");
        fmt(16'd1281, 16'd721, 1'b0, "x_post");
    endtask

    task automatic test_random();
        logic          rw;
        logic [7:0]    a;
        logic [15:0]   d;
        logic          fv;
        logic          fs;
        logic [15:0]   w;
        logic [15:0]   h;
        for (int n = 0; n < 200; n++) begin
            rw = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(5, 18));
            d = 16'($urandom);
            if (a == 8'd5) d = 16'($urandom_range(0, 2));
            if (a == 8'd7) d = ($urandom_range(0, 1) != 0) ?
                               16'd1280 : 16'd1920;
            if (a == 8'd8) d = ($urandom_range(0, 1) != 0) ?
                               16'd720 : 16'd1080;
            if (a == 8'd16) d = 16'($urandom_range(0, 3) != 0);
            fv = 1'($urandom_range(0, 1));
            fs = 1'($urandom_range(0, 1));
            w = ($urandom_range(0, 1) != 0) ? 16'd1280 : 16'd1920;
            h = ($urandom_range(0, 1) != 0) ? 16'd720 : 16'd1080;
            cycle_op(rw, a, d, fv, w, h, 1'($urandom_range(0, 1)), fs,
                     "rand");
        end
    endtask

    task automatic test_reset_stall();
        wr(8'd5, 16'd1, "r_sel1");
        wr(8'd6, 16'd0, "r_ctrl");
        wr(8'd7, 16'd1280, "r_w");
        wr(8'd8, 16'd720, "r_f0");
        wr(8'd16, 16'd1, "r_valid");
        fmt(16'd1280, 16'd720, 1'b0, "r_match");
        fstart("r_activate");
        frame_busy = 1'b1;
        write_trigger = 1'b1;
        av_address = 8'd9;
        av_writedata = 16'd7;
        @(negedge clk);
        chk++;
        if (av_write_ack !== 1'b0) begin
            err++;
            $display("FAIL r_stalled ack got %0b want 0", av_write_ack);
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("r_async");
        write_trigger = 1'b0;
        frame_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk++;
            if (av_write_ack !== 1'b0) begin
                err++;
                $display("FAIL r_noack%0d ack got %0b want 0",
                         i, av_write_ack);
            end
        end
        check_reset_outputs("r_after");
        fmt(16'd1920, 16'd1080, 1'b0, "r_bank0_match");
        fmt(16'd1280, 16'd720, 1'b0, "r_bank1_cleared");
        fmt(16'd1920, 16'd1080, 1'b0, "r_bank0_again");
        fstart("r_bank0_activate");
    endtask

    initial begin
        test_reset();
        test_match();
        test_stall();
        test_bad_sel();
        test_no_match_frame();
        test_simultaneous();
        test_random();
        test_reset_stall();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
